sensor_event_encoder: RTL

- Upstream stage of the crossing/traffic-light controller. Converts six raw, asynchronous, bouncy track-detector lines (d1..d6) into the 3-bit encoded sensor code the controller FSM consumes.
- Each qualified rising edge becomes a single code (d1→3'b001 … d6→3'b110), separated by idle code 3'b000.
- The controller's next-state logic is level-sensitive: a held code could cascade it through several states. This block therefore guarantees bounded-length codes with mandatory 000 gaps.
- Simultaneous detections are queued and serialized.

---
 rtl/sensor_event_encoder.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sensor_event_encoder.sv
// Turns six bouncy, asynchronous track-detector lines into one-at-a-time 3-bit
// event codes with guaranteed idle gaps, for the level-sensitive crossing controller.
`timescale 1ns/1ps

module sensor_event_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 1,
    parameter int GAP_CYCLES      = 1,
    parameter int STUCK_CYCLES    = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] det,
    output logic [2:0] sensor,
    output logic       code_valid,
    output logic [5:0] pending,
    output logic       overrun,
    output logic [5:0] stuck
);

    localparam int N_CH   = 6;
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int ST_W   = $clog2(STUCK_CYCLES + 1);
    localparam int PH_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_MAX    = ST_W'(STUCK_CYCLES);
    localparam logic [ST_W-1:0] ST_PRE    = ST_W'(STUCK_CYCLES - 1);
    localparam logic [PH_W-1:0] HOLD_LAST = PH_W'(HOLD_CYCLES - 1);
    localparam logic [PH_W-1:0] GAP_LAST  = PH_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    logic [5:0]      r_sync1;
    logic [5:0]      r_sync2;
    logic [5:0]      r_stable;
    logic [5:0]      r_stable_d;
    logic [DB_W-1:0] r_db_cnt [N_CH];
    logic [ST_W-1:0] r_st_cnt [N_CH];
    logic [5:0]      r_pending;
    logic            r_overrun;
    logic [5:0]      r_stuck;
    logic [2:0]      r_sensor;
    logic            r_code_valid;
    state_t          r_state;
    logic [PH_W-1:0] r_ph_cnt;

    logic [5:0]      w_stable_next;
    logic [DB_W-1:0] w_db_cnt_next [N_CH];
    logic [5:0]      w_rise;
    logic [5:0]      w_clear;
    logic [3:0]      w_sel;
    state_t          w_state_next;
    logic [PH_W-1:0] w_ph_cnt_next;
    logic [2:0]      w_sensor_next;
    logic            w_cv_next;

    // Lowest set request wins; returns {found, index}.
    function automatic logic [3:0] f_lowest(input logic [5:0] req);
        logic [3:0] sel;
        sel = 4'b0000;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel = {1'b1, 3'(i)};
            end
        end
        return sel;
    endfunction

    // Two-flop synchronizer per detector line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 6'b000000;
            r_sync2 <= 6'b000000;
        end else begin
            r_sync1 <= det;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: any sample agreeing with the stable level restarts qualification.
    always_comb begin
        w_stable_next = r_stable;
        for (int i = 0; i < N_CH; i++) begin
            w_db_cnt_next[i] = '0;
            if (r_sync2[i] != r_stable[i]) begin
                if (r_db_cnt[i] == DB_LAST) begin
                    w_stable_next[i] = r_sync2[i];
                    w_db_cnt_next[i] = '0;
                end else begin
                    w_db_cnt_next[i] = r_db_cnt[i] + DB_W'(1);
                end
            end else begin
                w_db_cnt_next[i] = '0;
            end
        end
    end

    // Debounce state and the delayed copy used for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stable   <= 6'b000000;
            r_stable_d <= 6'b000000;
            for (int i = 0; i < N_CH; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_stable   <= w_stable_next;
            r_stable_d <= r_stable;
            for (int i = 0; i < N_CH; i++) begin
                r_db_cnt[i] <= w_db_cnt_next[i];
            end
        end
    end

    assign w_rise = r_stable & ~r_stable_d;

    // Stuck-high detection counts stable-high cycles, saturating at the threshold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stuck <= 6'b000000;
            for (int i = 0; i < N_CH; i++) begin
                r_st_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (!w_stable_next[i]) begin
                    r_st_cnt[i] <= '0;
                    r_stuck[i]  <= 1'b0;
                end else if (r_st_cnt[i] != ST_MAX) begin
                    r_st_cnt[i] <= r_st_cnt[i] + ST_W'(1);
                    r_stuck[i]  <= (r_st_cnt[i] == ST_PRE);
                end else begin
                    r_stuck[i]  <= 1'b1;
                end
            end
        end
    end

    // Pending queue: a new edge beats a same-cycle clear, and only a truly
    // outstanding event turns a new edge into an overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 6'b000000;
            r_overrun <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | w_rise;
            r_overrun <= |(w_rise & r_pending & ~w_clear);
        end
    end

    assign w_sel = f_lowest(r_pending);

    // Emission FSM next-state and next-output logic.
    always_comb begin
        w_state_next  = r_state;
        w_ph_cnt_next = r_ph_cnt;
        w_sensor_next = r_sensor;
        w_cv_next     = r_code_valid;
        w_clear       = 6'b000000;
        case (r_state)
            S_IDLE: begin
                if (w_sel[3]) begin
                    w_sensor_next = w_sel[2:0] + 3'd1;
                    w_cv_next     = 1'b1;
                    w_clear       = 6'b000001 << w_sel[2:0];
                    w_ph_cnt_next = HOLD_LAST;
                    w_state_next  = S_EMIT;
                end else begin
                    w_sensor_next = 3'b000;
                    w_cv_next     = 1'b0;
                end
            end
            S_EMIT: begin
                if (r_ph_cnt == '0) begin
                    w_sensor_next = 3'b000;
                    w_cv_next     = 1'b0;
                    w_ph_cnt_next = GAP_LAST;
                    w_state_next  = S_GAP;
                end else begin
                    w_ph_cnt_next = r_ph_cnt - PH_W'(1);
                end
            end
            S_GAP: begin
                w_sensor_next = 3'b000;
                w_cv_next     = 1'b0;
                if (r_ph_cnt == '0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_ph_cnt_next = r_ph_cnt - PH_W'(1);
                end
            end
            default: begin
                w_sensor_next = 3'b000;
                w_cv_next     = 1'b0;
                w_ph_cnt_next = '0;
                w_state_next  = S_IDLE;
            end
        endcase
    end

    // Emission FSM state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ph_cnt     <= '0;
            r_sensor     <= 3'b000;
            r_code_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ph_cnt     <= w_ph_cnt_next;
            r_sensor     <= w_sensor_next;
            r_code_valid <= w_cv_next;
        end
    end

    assign sensor     = r_sensor;
    assign code_valid = r_code_valid;
    assign pending    = r_pending;
    assign overrun    = r_overrun;
    assign stuck      = r_stuck;

    sensor_event_encoder_chk u_chk (
        .clk        (clk),
        .reset      (reset),
        .sensor     (r_sensor),
        .code_valid (r_code_valid)
    );

endmodule

// Output-protocol properties for the encoder.
module sensor_event_encoder_chk (
    input logic       clk,
    input logic       reset,
    input logic [2:0] sensor,
    input logic       code_valid
);

    a_no_code_7: assert property (@(posedge clk) disable iff (reset) sensor != 3'b111);
    a_valid_tracks_code: assert property (@(posedge clk) disable iff (reset)
        code_valid == (sensor != 3'b000));

endmodule
